// File: rtl/fp_pkg.sv
// Shared constants for the FP datapath arithmetic primitives.
package fp_pkg;

    // Default operand/sum width of the integer adder.
    localparam int unsigned ADDER_W = 8;

endpackage : fp_pkg

// File: rtl/nbit_full_adder_if.sv
// Operand/result bundle for the registered N-bit adder.
interface nbit_full_adder_if
    import fp_pkg::*;
#(
    parameter int unsigned N = ADDER_W
);

    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;

    logic [N-1:0] sum;
    logic         co;
    logic         ovf;
    logic         out_valid;

    // Producer of operands, consumer of results.
    modport master (
        output in_valid,
        output a,
        output b,
        output ci,
        input  sum,
        input  co,
        input  ovf,
        input  out_valid
    );

    // The adder itself.
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  ci,
        output sum,
        output co,
        output ovf,
        output out_valid
    );

endinterface : nbit_full_adder_if

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; the ripple chain in nbit_full_adder is built from these.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the parity of the three inputs, carry is their majority.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule : full_adder_bit

// File: rtl/nbit_full_adder.sv
// Registered N-bit ripple-carry adder: {co,sum} = a + b + ci, plus signed overflow.
// Subtraction is done by the caller as a + ~b with ci=1 (co=1 then means a >= b).
// N must be at least 2 and must match the width the interface was built with.
module nbit_full_adder
    import fp_pkg::*;
#(
    parameter int unsigned N = ADDER_W
) (
    input  logic               clk,
    input  logic               rst_n,
    nbit_full_adder_if.slave   bus
);

    logic [N:0]   carry;
    logic [N-1:0] sum_c;
    logic         ovf_c;

    assign carry[0] = bus.ci;

    // Ripple chain: carry[i] feeds bit i, carry[N] is the unsigned carry out.
    for (genvar i = 0; i < int'(N); i++) begin : g_bit
        full_adder_bit u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (carry[i]),
            .s  (sum_c[i]),
            .co (carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    always_comb begin
        ovf_c = carry[N] ^ carry[N-1];
    end

    // Output stage: capture on valid, hold otherwise; valid is a one-cycle echo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum       <= '0;
            bus.co        <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum <= sum_c;
                bus.co  <= carry[N];
                bus.ovf <= ovf_c;
            end
        end
    end

endmodule : nbit_full_adder

// File: tb/tb_nbit_full_adder.sv
// Self-checking bench for nbit_full_adder at N=8 and N=16.
module tb_nbit_full_adder;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    nbit_full_adder_if #(.N(8))  if8  ();
    nbit_full_adder_if #(.N(16)) if16 ();

    nbit_full_adder #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    nbit_full_adder #(.N(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic void ref_add(input int n, input longint a, input longint b, input longint ci,
                                    output longint s, output longint co, output longint ovf);
        longint m, half, full, sa, sb, ss;
        m    = longint'(1) << n;
        half = m / 2;
        full = a + b + ci;
        s    = full % m;
        co   = (full >= m) ? 1 : 0;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        ss   = sa + sb + ci;
        ovf  = (ss >= half || ss < -half) ? 1 : 0;
    endfunction

    // Present one valid operand set to the 8-bit DUT and step past the capturing edge.
    task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.a        = a;
        if8.b        = b;
        if8.ci       = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic expect8(input string tag, input logic [7:0] s, input logic co, input logic ovf);
        check({tag, ".valid"}, 32'(if8.out_valid), 32'(1'b1));
        check({tag, ".sum"},   32'(if8.sum),       32'(s));
        check({tag, ".co"},    32'(if8.co),        32'(co));
        check({tag, ".ovf"},   32'(if8.ovf),       32'(ovf));
    endtask

    task automatic expect_zero(input string tag);
        check({tag, ".v8"},   32'(if8.out_valid),  32'(0));
        check({tag, ".s8"},   32'(if8.sum),        32'(0));
        check({tag, ".co8"},  32'(if8.co),         32'(0));
        check({tag, ".ov8"},  32'(if8.ovf),        32'(0));
        check({tag, ".v16"},  32'(if16.out_valid), 32'(0));
        check({tag, ".s16"},  32'(if16.sum),       32'(0));
    endtask

    initial begin
        longint es8, ec8, eo8, es16, ec16, eo16;
        logic   ev8, ev16;
        longint ra, rb, rc, ts, tc, tov;

        checks = 0;
        errors = 0;

        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.ci  = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.ci = 1'b0;

        // Reset state
        rst_n = 1'b0;
        #1;
        expect_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases, applied back-to-back
        apply8(8'hFC, 8'h0A, 1'b0); expect8("neg4_plus10",   8'h06, 1'b1, 1'b0);
        apply8(8'hF6, 8'h04, 1'b0); expect8("neg10_plus4",   8'hFA, 1'b0, 1'b0);
        apply8(8'h04, 8'hF6, 1'b0); expect8("plus4_neg10",   8'hFA, 1'b0, 1'b0);
        apply8(8'hFC, 8'hF6, 1'b0); expect8("neg4_neg10",    8'hF2, 1'b1, 1'b0);
        apply8(8'h7F, 8'h01, 1'b0); expect8("maxpos_plus1",  8'h80, 1'b0, 1'b1);
        apply8(8'hFF, 8'h00, 1'b1); expect8("allones_ci",    8'h00, 1'b1, 1'b0);
        apply8(8'h05, 8'hFC, 1'b1); expect8("sub_5_minus_3", 8'h02, 1'b1, 1'b0);
        apply8(8'h03, 8'hFA, 1'b1); expect8("sub_3_minus_5", 8'hFE, 1'b0, 1'b0);
        apply8(8'h80, 8'h80, 1'b0); expect8("minneg_x2",     8'h00, 1'b1, 1'b1);

        // Idle edge: valid drops, result registers hold
        @(negedge clk);
        if8.in_valid = 1'b0;
        if8.a        = 8'h12;
        if8.b        = 8'h34;
        @(posedge clk);
        #1;
        check("hold.valid", 32'(if8.out_valid), 32'(0));
        check("hold.sum",   32'(if8.sum),       32'(8'h00));
        check("hold.co",    32'(if8.co),        32'(1));
        check("hold.ovf",   32'(if8.ovf),       32'(1));

        // Async reset in the middle of a valid stream
        apply8(8'h01, 8'h02, 1'b0); expect8("pre_reset", 8'h03, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_zero("async_reset");
        @(posedge clk);
        #1;
        expect_zero("reset_held");
        @(negedge clk);
        rst_n        = 1'b1;
        if8.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            expect_zero("post_release");
        end

        // Random stream on both widths with valid toggling
        es8 = 0; ec8 = 0; eo8 = 0; es16 = 0; ec16 = 0; eo16 = 0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if8.in_valid  = 1'($urandom_range(0, 1));
            if8.a         = 8'($urandom);
            if8.b         = 8'($urandom);
            if8.ci        = 1'($urandom);
            if16.in_valid = 1'($urandom_range(0, 1));
            if16.a        = 16'($urandom);
            if16.b        = 16'($urandom);
            if16.ci       = 1'($urandom);

            ev8 = if8.in_valid;
            if (ev8) begin
                ra = longint'(if8.a); rb = longint'(if8.b); rc = longint'(if8.ci);
                ref_add(8, ra, rb, rc, ts, tc, tov);
                es8 = ts; ec8 = tc; eo8 = tov;
            end
            ev16 = if16.in_valid;
            if (ev16) begin
                ra = longint'(if16.a); rb = longint'(if16.b); rc = longint'(if16.ci);
                ref_add(16, ra, rb, rc, ts, tc, tov);
                es16 = ts; ec16 = tc; eo16 = tov;
            end

            @(posedge clk);
            #1;
            check("rnd8.valid",  32'(if8.out_valid),  32'(ev8));
            check("rnd8.sum",    32'(if8.sum),        32'(es8));
            check("rnd8.co",     32'(if8.co),         32'(ec8));
            check("rnd8.ovf",    32'(if8.ovf),        32'(eo8));
            check("rnd16.valid", 32'(if16.out_valid), 32'(ev16));
            check("rnd16.sum",   32'(if16.sum),       32'(es16));
            check("rnd16.co",    32'(if16.co),        32'(ec16));
            check("rnd16.ovf",   32'(if16.ovf),       32'(eo16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nbit_full_adder
